// File: rtl/keypad_scan_ctrl_if.sv
// Signal bundle between the 4x4 keypad scan controller and its surroundings.
// The master side is the controller; the slave side is the keypad/synchronizer/decoder.
interface keypad_scan_ctrl_if;
    logic [3:0] cols_sync;
    logic [3:0] rows;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_held;

    modport master (
        input  cols_sync,
        output rows,
        output key_valid,
        output key_code,
        output key_held
    );

    modport slave (
        output cols_sync,
        input  rows,
        input  key_valid,
        input  key_code,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: walks active-low rows, debounces press and release on one column,
// and emits a single key_valid pulse with the {row, column} one-cold code per press.
module keypad_scan_ctrl #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic                clk,
    input  logic                reset,
    keypad_scan_ctrl_if.master  kp
);

    localparam int MAX_CNT = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        SETTLE,
        CHECK,
        DEBOUNCE,
        EMIT,
        HOLD,
        RELEASE
    } state_t;

    state_t           state, state_n;
    logic [1:0]       row_idx, row_idx_n;
    logic [1:0]       cand_col, cand_col_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       rows_q, rows_n;
    logic             key_valid_q, key_valid_n;
    logic [7:0]       key_code_q, key_code_n;
    logic             key_held_q, key_held_n;
    logic             advance;
    logic [1:0]       first_low;
    logic             cand_bit;

    function automatic logic [3:0] one_cold(input logic [1:0] idx);
        logic [3:0] v;
        v      = 4'b1111;
        v[idx] = 1'b0;
        return v;
    endfunction

    // Lowest-index pressed column wins when several columns read low together.
    always_comb begin
        first_low = 2'd3;
        if (!kp.cols_sync[0])      first_low = 2'd0;
        else if (!kp.cols_sync[1]) first_low = 2'd1;
        else if (!kp.cols_sync[2]) first_low = 2'd2;
    end

    assign cand_bit = kp.cols_sync[cand_col];

    always_comb begin
        state_n     = state;
        row_idx_n   = row_idx;
        cand_col_n  = cand_col;
        cnt_n       = cnt;
        rows_n      = rows_q;
        key_valid_n = 1'b0;
        key_code_n  = key_code_q;
        key_held_n  = key_held_q;
        advance     = 1'b0;

        case (state)
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_n   = '0;
                    state_n = CHECK;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            CHECK: begin
                cnt_n = '0;
                if (kp.cols_sync == 4'b1111) begin
                    advance = 1'b1;
                    state_n = SETTLE;
                end else begin
                    cand_col_n = first_low;
                    state_n    = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!cand_bit) begin
                    if (cnt == DEBOUNCE_LAST) begin
                        cnt_n       = '0;
                        state_n     = EMIT;
                        key_valid_n = 1'b1;
                        key_code_n  = {rows_q, one_cold(cand_col)};
                        key_held_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    cnt_n   = '0;
                    advance = 1'b1;
                    state_n = SETTLE;
                end
            end
            EMIT: begin
                state_n = HOLD;
            end
            HOLD: begin
                if (cand_bit) begin
                    cnt_n   = '0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (cand_bit) begin
                    if (cnt == DEBOUNCE_LAST) begin
                        cnt_n      = '0;
                        key_held_n = 1'b0;
                        advance    = 1'b1;
                        state_n    = SETTLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    cnt_n   = '0;
                    state_n = HOLD;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = SETTLE;
            end
        endcase

        // Rows only move when a slot ends without holding a key.
        if (advance) begin
            row_idx_n = row_idx + 2'd1;
            rows_n    = one_cold(row_idx_n);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= SETTLE;
            row_idx     <= 2'd0;
            cand_col    <= 2'd0;
            cnt         <= '0;
            rows_q      <= 4'b1110;
            key_valid_q <= 1'b0;
            key_code_q  <= 8'hFF;
            key_held_q  <= 1'b0;
        end else begin
            state       <= state_n;
            row_idx     <= row_idx_n;
            cand_col    <= cand_col_n;
            cnt         <= cnt_n;
            rows_q      <= rows_n;
            key_valid_q <= key_valid_n;
            key_code_q  <= key_code_n;
            key_held_q  <= key_held_n;
        end
    end

    assign kp.rows      = rows_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a combinational keypad model pulls columns low for
// pressed keys on the driven row; expected timings are hand-computed for the defaults.
module tb_keypad_scan_ctrl;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] press_mask = 16'h0;
    logic [3:0]  cols;

    keypad_scan_ctrl_if kif ();

    keypad_scan_ctrl #(
        .SETTLE_CYCLES   (4),
        .DEBOUNCE_CYCLES (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    always #5 clk = ~clk;

    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press_mask[r*4 + c] && kif.rows[r] === 1'b0) cols[c] = 1'b0;
    end
    assign kif.cols_sync = cols;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         pulses   = 0;
    int         pulse_cyc = -1;
    int         fall_cyc  = -1;
    int         back_to_back = 0;
    int         base = 0;
    int         w = 0;
    logic [7:0] pulse_code = 8'h00;
    logic       prev_valid = 1'b0;
    logic       prev_held  = 1'b0;
    logic [3:0] walk [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] mask);
        press_mask = mask;
    endtask

    function automatic logic [15:0] key(input int r, input int c);
        logic [15:0] m;
        m = 16'h0;
        m[r*4 + c] = 1'b1;
        return m;
    endfunction

    // Advance one clock and record pulse/fall events for later comparison.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (kif.key_valid === 1'b1) begin
            pulses++;
            pulse_cyc  = cyc;
            pulse_code = kif.key_code;
            if (prev_valid === 1'b1) back_to_back++;
        end
        prev_valid = kif.key_valid;
        if (prev_held === 1'b1 && kif.key_held === 1'b0) fall_cyc = cyc;
        prev_held = kif.key_held;
    endtask

    task automatic runTo(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(16'h0);
        reset = 1'b0;
        repeat (3) begin
            tick();
            checkOutput("reset_rows", kif.rows, 4'b1110);
            checkOutput("reset_valid", kif.key_valid, 1'b0);
            checkOutput("reset_held", kif.key_held, 1'b0);
            checkOutput("reset_code", kif.key_code, 8'hFF);
        end
        reset = 1'b1;
        for (int i = 0; i < 25; i++) begin
            checkOutput("scan_walk", kif.rows, walk[i/5]);
            tick();
        end

        // Short presses on row 0 / col 3 that never reach the debounce count.
        pulses = 0;
        for (int rep = 0; rep < 3; rep++) begin
            w = 0;
            do begin
                tick();
                w++;
            end while (kif.rows !== 4'b1110 && w < 40);
            checkOutput("bounce_wait_row0", kif.rows, 4'b1110);
            applyStimulus(key(0, 3));
            repeat (10) tick();
            applyStimulus(16'h0);
            checkOutput("bounce_rows_stable", kif.rows, 4'b1110);
            tick();
            checkOutput("bounce_row_advance", kif.rows, 4'b1101);
        end
        checkOutput("bounce_no_pulse", pulses, 0);
        checkOutput("bounce_code", kif.key_code, 8'hFF);
        checkOutput("bounce_held", kif.key_held, 1'b0);

        // Clean press row 2 / col 1, starting at the row 1 slot.
        base = cyc;
        pulses = 0;
        applyStimulus(key(2, 1));
        runTo(base + 60);
        checkOutput("clean_held", kif.key_held, 1'b1);
        runTo(base + 100);
        applyStimulus(16'h0);
        runTo(base + 131);
        checkOutput("clean_pulses", pulses, 1);
        checkOutput("clean_latency", pulse_cyc - base, 30);
        checkOutput("clean_code_at_pulse", pulse_code, 8'b1011_1101);
        checkOutput("clean_release_fall", fall_cyc - base, 121);
        checkOutput("clean_code_holds", kif.key_code, 8'b1011_1101);
        checkOutput("clean_rows_after", kif.rows, 4'b1101);

        // Hold row 1 / col 0, then add other keys that must be ignored.
        base = cyc;
        pulses = 0;
        applyStimulus(key(1, 0));
        runTo(base + 30);
        applyStimulus(key(1, 0) | key(1, 2) | key(3, 3));
        while (cyc < base + 60) begin
            tick();
            checkOutput("hold_rows", kif.rows, 4'b1101);
        end
        applyStimulus(16'h0);
        while (cyc < base + 80) begin
            tick();
            checkOutput("hold_release_rows", kif.rows, 4'b1101);
        end
        tick();
        checkOutput("hold_rows_advance", kif.rows, 4'b1011);
        checkOutput("hold_pulses", pulses, 1);
        checkOutput("hold_latency", pulse_cyc - base, 25);
        checkOutput("hold_code", pulse_code, 8'b1101_1110);
        checkOutput("hold_fall", fall_cyc - base, 81);
        runTo(base + 96);

        // Release bounce: 8 high, 5 low, then clean release.
        base = cyc;
        pulses = 0;
        applyStimulus(key(1, 0));
        runTo(base + 40);
        applyStimulus(16'h0);
        runTo(base + 47);
        checkOutput("relb_held_mid", kif.key_held, 1'b1);
        runTo(base + 48);
        applyStimulus(key(1, 0));
        runTo(base + 53);
        applyStimulus(16'h0);
        checkOutput("relb_held_back", kif.key_held, 1'b1);
        runTo(base + 73);
        checkOutput("relb_held_last", kif.key_held, 1'b1);
        checkOutput("relb_rows_last", kif.rows, 4'b1101);
        tick();
        checkOutput("relb_held_fall", kif.key_held, 1'b0);
        checkOutput("relb_rows_advance", kif.rows, 4'b1011);
        checkOutput("relb_pulses", pulses, 1);
        checkOutput("relb_latency", pulse_cyc - base, 25);
        checkOutput("relb_fall", fall_cyc - base, 74);
        runTo(base + 84);

        // Two columns low on row 0: column 1 is chosen.
        base = cyc;
        pulses = 0;
        applyStimulus(key(0, 1) | key(0, 3));
        runTo(base + 30);
        applyStimulus(16'h0);
        runTo(base + 51);
        checkOutput("multi_pulses", pulses, 1);
        checkOutput("multi_latency", pulse_cyc - base, 25);
        checkOutput("multi_code", pulse_code, 8'b1110_1101);
        checkOutput("multi_fall", fall_cyc - base, 51);
        checkOutput("multi_rows_after", kif.rows, 4'b1101);
        runTo(base + 66);

        // Same press, with reset landing on debounce sample 10.
        base = cyc;
        pulses = 0;
        applyStimulus(key(0, 1) | key(0, 3));
        runTo(base + 14);
        reset = 1'b0;
        tick();
        checkOutput("midrst_rows", kif.rows, 4'b1110);
        checkOutput("midrst_valid", kif.key_valid, 1'b0);
        checkOutput("midrst_held", kif.key_held, 1'b0);
        checkOutput("midrst_code", kif.key_code, 8'hFF);
        reset = 1'b1;
        runTo(base + 39);
        checkOutput("midrst_no_early_pulse", pulses, 0);
        tick();
        checkOutput("midrst_valid_high", kif.key_valid, 1'b1);
        checkOutput("midrst_code_redetect", kif.key_code, 8'b1110_1101);
        tick();
        checkOutput("midrst_valid_single", kif.key_valid, 1'b0);
        checkOutput("midrst_pulses", pulses, 1);
        checkOutput("no_back_to_back", back_to_back, 0);
        applyStimulus(16'h0);
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

- Sequences the 4x4 keypad datapath: drives rows one at a time (active-low), samples the synchronized columns and debounces press and release.
- Emits exactly one single-cycle `key_valid` pulse per debounced key press, with the `{row, col}` code.
- Sits between the column synchronizer and the key decoder/display registers.
- Runs on the divided system clock.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 4: cycles a row is driven before columns are sampled; minimum 1.
- `DEBOUNCE_CYCLES`, default 20: consecutive stable samples required to accept a press or a release; minimum 1.

Ports:
- `clk` in 1: divided system clock.
- `reset` in 1: reset, synchronous, active-low.
- `cols_sync` in 4: columns, already two-flop synchronized, active-low (0 = pressed).
- `rows` out 4: row drive, active-low one-cold.
- `key_valid` out 1: one-cycle pulse when a debounced press is accepted.
- `key_code` out 8: `{rows pattern, column pattern}`, both one-cold active-low; holds its value until the next `key_valid`.
- `key_held` out 1: high while the accepted key remains pressed.

## Operation

- Registered outputs and states: SETTLE, CHECK, DEBOUNCE, EMIT, HOLD, RELEASE.
- Reset values (applied while `reset`=0 on a clk edge):
  - state SETTLE, row index 0, `rows`=4'b1110
  - all counters 0
  - `key_valid`=0, `key_held`=0, `key_code`=8'hFF
- SETTLE: drive current row; count to `SETTLE_CYCLES`-1, then go to CHECK.
- CHECK (1 cycle):
  - `cols_sync`==4'b1111: advance row index (3 wraps to 0), update `rows`, clear counter, go to SETTLE.
  - Otherwise: latch the candidate column as the lowest-index 0 bit of `cols_sync`. Other low bits are ignored. Clear counter, go to DEBOUNCE.
- DEBOUNCE: row stays driven; sample the candidate column bit each cycle.
  - Bit low: increment the counter. On the `DEBOUNCE_CYCLES`-th consecutive low sample, go to EMIT.
  - Bit high (bounce): abort, advance row, go to SETTLE. No output changes.
- EMIT (1 cycle): `key_valid`=1; `key_code`={current `rows`, candidate column one-cold}; `key_held` rises; go to HOLD.
- HOLD:
  - Row stays driven; `key_held`=1; all other columns and keys are ignored.
  - When the candidate bit goes high: clear counter, go to RELEASE.
- RELEASE:
  - Candidate bit high: increment the counter. At `DEBOUNCE_CYCLES` consecutive high samples, `key_held`=0, advance row, go to SETTLE.
  - Candidate bit low again: return to HOLD. No new `key_valid`.
- `key_valid` is never high for two consecutive cycles. It is never reasserted without passing through RELEASE completion.
- A reset in any state overrides everything on that edge.
  - A press being debounced at reset is discarded.
  - A key still held after reset is re-detected as a new press by the normal scan.

## Timing

- One row slot (no press) = `SETTLE_CYCLES`+1 cycles. Full scan = 4*(`SETTLE_CYCLES`+1); defaults give 20 cycles.
- Press latency: CHECK at cycle t0 sees the low bit. `key_valid` is high at cycle t0+`DEBOUNCE_CYCLES`+1. `key_code` is valid in the same cycle and afterwards.
- Release latency: the first high sample in HOLD is cycle r0. `key_held` falls at r0+`DEBOUNCE_CYCLES`+1. Scanning of the next row starts on that cycle.
- `rows` changes only on SETTLE entry from CHECK or RELEASE. `rows` is stable in DEBOUNCE, EMIT, HOLD and RELEASE.

## Test plan

- Reset: hold `reset`=0 for 3 cycles, then release.
  - During reset: `rows`=4'b1110, `key_valid`=0, `key_held`=0, `key_code`=8'hFF.
  - Afterwards `rows` walks 1110, 1101, 1011, 0111, 1110, each held for 5 cycles (defaults).
- Clean press: press row 2 / col 1 (`cols_sync`=4'b1101 only while `rows`=4'b1011) for 100 cycles.
  - Exactly one `key_valid` pulse, `key_code`=8'b1011_1101.
  - `key_held` falls 21 cycles after release.
- Bounce rejection: press row 0 / col 3 for 10 cycles only (< 20), repeated across 3 scans.
  - No `key_valid`; `key_code` stays 8'hFF; scan continues.
- Hold plus second key: hold row 1 / col 0 and accept it. Then press row 1 / col 2 and row 3 / col 3 while the first key is held.
  - Only the first pulse occurs (`key_code`=8'b1101_1110); `rows` stays 4'b1101 until the first key's release completes.
- Release bounce: in HOLD, raise the candidate bit for 8 cycles, drop it low for 5 cycles, then release cleanly.
  - Return to HOLD with no new `key_valid`; `key_held` stays 1 until the clean release plus 21 cycles.
- Simultaneous columns and mid-operation reset: drive `cols_sync`=4'b0101 on row 0.
  - Col 1 is chosen; `key_code`=8'b1110_1101.
  - Repeat, asserting reset at debounce sample 10: no pulse, reset values next cycle, then re-detection and a pulse 21 cycles after the next CHECK of row 0.
